err_inject_ctrl: RTL and testbench

Parametrised successor to the fixed single-bit error injector on the 8b/10b output path. It sits between the 66b-to-8b10b converter output and the link-model checker. It corrupts whole words of DATA_W bits in one of three modes (random rate, single-shot, burst) and flips 1..MAX_FLIPS adjacent bits per corrupted word. It registers data, flip mask and a saturating injection counter, so the checker can correlate detected errors with injected ones.

---
 rtl/err_inject_pkg.sv | 22 ++
 rtl/err_inject_ctrl_if.sv | 38 +++
 rtl/err_lfsr32.sv | 34 +++
 rtl/err_inject_ctrl.sv | 156 +++++++++++++++
 tb/tb_err_inject_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/err_inject_pkg.sv
// Shared encodings and constants for the error injector and its LFSR.
package err_inject_pkg;

    localparam int unsigned LFSR_W = 32;

    localparam logic [LFSR_W-1:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_0001;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_RAND  = 2'b01,
        MODE_SHOT  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_BURST = 2'b10
    } state_e;

endpackage

// File: rtl/err_inject_ctrl_if.sv
// Data path and control bundle of the error injector; the DUT uses the slave side.
interface err_inject_ctrl_if #(
    parameter int unsigned DATA_W    = 80,
    parameter int unsigned RATE_W    = 16,
    parameter int unsigned MAX_FLIPS = 4,
    parameter int unsigned BURST_W   = 8,
    parameter int unsigned CNT_W     = 32
);
    localparam int unsigned NF_W = $clog2(MAX_FLIPS + 1);

    logic               en;
    logic               din_valid;
    logic [DATA_W-1:0]  din;
    logic [1:0]         mode;
    logic [RATE_W-1:0]  rate;
    logic [NF_W-1:0]    num_flips;
    logic               trigger;
    logic [BURST_W-1:0] burst_len;
    logic               clr_count;

    logic               dout_valid;
    logic [DATA_W-1:0]  dout;
    logic [DATA_W-1:0]  err_mask;
    logic               err_flag;
    logic [CNT_W-1:0]   inj_count;
    logic               busy;

    modport master (
        output en, din_valid, din, mode, rate, num_flips, trigger, burst_len, clr_count,
        input  dout_valid, dout, err_mask, err_flag, inj_count, busy
    );

    modport slave (
        input  en, din_valid, din, mode, rate, num_flips, trigger, burst_len, clr_count,
        output dout_valid, dout, err_mask, err_flag, inj_count, busy
    );

endinterface

// File: rtl/err_lfsr32.sv
// 32-bit right-shifting Galois LFSR with advance enable and reset seed.
module err_lfsr32
    import err_inject_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] POLY = LFSR_POLY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/err_inject_ctrl.sv
// Word-level error injector: random, single-shot and burst corruption of
// adjacent bits, with registered data, mask and saturating injection count.
module err_inject_ctrl
    import err_inject_pkg::*;
#(
    parameter int unsigned       DATA_W    = 80,
    parameter int unsigned       RATE_W    = 16,
    parameter int unsigned       MAX_FLIPS = 4,
    parameter int unsigned       BURST_W   = 8,
    parameter int unsigned       CNT_W     = 32,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    err_inject_ctrl_if.slave  bus
);

    localparam int unsigned NF_W  = $clog2(MAX_FLIPS + 1);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    // Adjacent-bit mask starting at sel mod DATA_W, wrapping to bit 0.
    function automatic logic [DATA_W-1:0] flip_mask(input logic [15:0] sel,
                                                    input logic [NF_W-1:0] nf);
        logic [DATA_W-1:0] m;
        logic [IDX_W-1:0]  pos;
        logic [NF_W-1:0]   n;
        m   = '0;
        n   = (nf == '0) ? NF_W'(1) : ((32'(nf) > MAX_FLIPS) ? NF_W'(MAX_FLIPS) : nf);
        pos = IDX_W'(32'(sel) % DATA_W);
        for (int unsigned i = 0; i < MAX_FLIPS; i++) begin
            if (i < 32'(n)) begin
                m[pos] = 1'b1;
            end
            pos = (32'(pos) == DATA_W - 1) ? '0 : pos + IDX_W'(1);
        end
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [BURST_W-1:0] bcnt_q, bcnt_d;
    logic               dout_valid_q, dout_valid_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [DATA_W-1:0]  err_mask_q, err_mask_d;
    logic               err_flag_q, err_flag_d;
    logic [CNT_W-1:0]   inj_count_q, inj_count_d;
    logic               busy_q, busy_d;

    logic [LFSR_W-1:0]  lfsr;
    logic               word_c;
    logic               corrupt_c;
    mode_e              mode_c;

    assign mode_c = mode_e'(bus.mode);
    assign word_c = bus.en && bus.din_valid;

    err_lfsr32 #(
        .SEED (SEED),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .adv   (word_c),
        .state (lfsr)
    );

    // Corruption decision, FSM next state and registered output values.
    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        corrupt_c    = 1'b0;

        if (bus.en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (word_c && mode_c == MODE_RAND) begin
                        corrupt_c = (lfsr[RATE_W-1:0] < bus.rate);
                    end
                    // A triggering word itself is never corrupted.
                    if (bus.trigger && mode_c == MODE_SHOT) begin
                        state_d = ST_ARMED;
                    end else if (bus.trigger && mode_c == MODE_BURST) begin
                        state_d = ST_BURST;
                        bcnt_d  = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;
                    end
                end
                ST_ARMED: begin
                    if (mode_c != MODE_SHOT) begin
                        state_d = ST_IDLE;
                    end else if (word_c) begin
                        corrupt_c = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (mode_c != MODE_BURST) begin
                        state_d = ST_IDLE;
                        bcnt_d  = '0;
                    end else if (word_c) begin
                        corrupt_c = 1'b1;
                        bcnt_d    = bcnt_q - BURST_W'(1);
                        if (bcnt_q == BURST_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bcnt_d  = '0;
                end
            endcase
        end

        err_mask_d   = corrupt_c ? flip_mask(lfsr[31:16], bus.num_flips) : '0;
        dout_d       = bus.din ^ err_mask_d;
        dout_valid_d = bus.din_valid;
        err_flag_d   = |err_mask_d;
        busy_d       = (state_d != ST_IDLE);

        inj_count_d = inj_count_q;
        if (bus.clr_count) begin
            inj_count_d = '0;
        end else if (corrupt_c && inj_count_q != '1) begin
            inj_count_d = inj_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bcnt_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            err_mask_q   <= '0;
            err_flag_q   <= 1'b0;
            inj_count_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            err_mask_q   <= err_mask_d;
            err_flag_q   <= err_flag_d;
            inj_count_q  <= inj_count_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.err_mask   = err_mask_q;
    assign bus.err_flag   = err_flag_q;
    assign bus.inj_count  = inj_count_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_err_inject_ctrl.sv
// Scoreboard bench for err_inject_ctrl: stimulus pushes expected words,
// a monitor pops and compares every registered output cycle.
module tb_err_inject_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    err_inject_ctrl_if #(.CNT_W(32)) bus ();
    err_inject_ctrl_if #(.CNT_W(4))  bus4 ();

    err_inject_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    err_inject_ctrl #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    assign bus4.en        = bus.en;
    assign bus4.din_valid = bus.din_valid;
    assign bus4.din       = bus.din;
    assign bus4.mode      = bus.mode;
    assign bus4.rate      = bus.rate;
    assign bus4.num_flips = bus.num_flips;
    assign bus4.trigger   = bus.trigger;
    assign bus4.burst_len = bus.burst_len;
    assign bus4.clr_count = bus.clr_count;

    typedef struct {
        logic        vld;
        logic [79:0] dout;
        logic [79:0] mask;
        logic        busy;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    // Configuration applied by the next step() at its negedge.
    logic        t_en   = 1'b1;
    logic [1:0]  t_mode = 2'b00;
    logic [15:0] t_rate = '0;
    logic [2:0]  t_nf   = 3'd4;
    logic [7:0]  t_blen = '0;

    // Reference model state: lfsr, fsm (0 idle, 1 armed, 2 burst), counters.
    logic [31:0] m_lfsr;
    int          m_state;
    int          m_bcnt;
    logic [31:0] m_inj;
    logic [3:0]  m_inj4;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [79:0] ref_mask(input logic [15:0] hi, input logic [2:0] nf);
        logic [79:0] m;
        int n;
        int p;
        n = (nf == 3'd0) ? 1 : ((nf > 3'd4) ? 4 : int'({29'd0, nf}));
        p = int'({16'd0, hi}) % 80;
        m = '0;
        for (int k = 0; k < n; k++) m[7'((p + k) % 80)] = 1'b1;
        return m;
    endfunction

    function automatic int pos0(input logic [31:0] s);
        return int'({16'd0, s[31:16]}) % 80;
    endfunction

    task automatic model_reset();
        m_lfsr  = 32'hACE1_0001;
        m_state = 0;
        m_bcnt  = 0;
        m_inj   = '0;
        m_inj4  = '0;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, predict its registered response and queue it.
    task automatic step(input logic v, input logic [79:0] d, input logic trig, input logic clr);
        exp_t e;
        logic corrupt;
        @(negedge clk);
        bus.en        = t_en;
        bus.mode      = t_mode;
        bus.rate      = t_rate;
        bus.num_flips = t_nf;
        bus.burst_len = t_blen;
        bus.din_valid = v;
        bus.din       = d;
        bus.trigger   = trig;
        bus.clr_count = clr;

        corrupt = 1'b0;
        if (t_en && v) begin
            case (t_mode)
                2'b01:   corrupt = (m_state == 0) && (m_lfsr[15:0] < t_rate);
                2'b10:   corrupt = (m_state == 1);
                2'b11:   corrupt = (m_state == 2);
                default: corrupt = 1'b0;
            endcase
        end
        e.mask = corrupt ? ref_mask(m_lfsr[31:16], t_nf) : '0;
        e.vld  = v;
        e.dout = d ^ e.mask;

        if (t_en) begin
            case (m_state)
                0: begin
                    if (trig && t_mode == 2'b10) m_state = 1;
                    else if (trig && t_mode == 2'b11) begin
                        m_state = 2;
                        m_bcnt  = (t_blen == 8'd0) ? 1 : int'({24'd0, t_blen});
                    end
                end
                1: if (t_mode != 2'b10 || v) m_state = 0;
                2: begin
                    if (t_mode != 2'b11) begin
                        m_state = 0;
                        m_bcnt  = 0;
                    end else if (v) begin
                        m_bcnt--;
                        if (m_bcnt == 0) m_state = 0;
                    end
                end
                default: m_state = 0;
            endcase
            if (v) m_lfsr = lfsr_next(m_lfsr);
        end

        if (clr) begin
            m_inj  = '0;
            m_inj4 = '0;
        end else if (corrupt) begin
            if (m_inj != 32'hFFFF_FFFF) m_inj = m_inj + 32'd1;
            if (m_inj4 != 4'hF) m_inj4 = m_inj4 + 4'd1;
        end
        e.busy = (m_state != 0);
        e.cnt  = m_inj;
        e.cnt4 = m_inj4;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [79:0] rnd80();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    // Advance the LFSR with pass-through words until pos0 hits target.
    task automatic seek_pos(input int target);
        int k;
        k = 0;
        t_mode = 2'b00;
        while (pos0(m_lfsr) != target && k < 4000) begin
            step(1'b1, rnd80(), 1'b0, 1'b0);
            k++;
        end
        chk("seek_pos", 80'(pos0(m_lfsr)), 80'(target));
    endtask

    // Monitor: pop one expectation per registered output cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && q.size() > 0) begin
                mon_e = q.pop_front();
                checks++;
                if (bus.dout_valid !== mon_e.vld || bus.dout !== mon_e.dout ||
                    bus.err_mask !== mon_e.mask || bus.err_flag !== (mon_e.mask != '0) ||
                    bus.busy !== mon_e.busy || bus.inj_count !== mon_e.cnt ||
                    bus4.inj_count !== mon_e.cnt4) begin
                    errors++;
                    $display("FAIL word: vld %0b/%0b dout %h/%h mask %h/%h flag %0b busy %0b/%0b cnt %0d/%0d cnt4 %0d/%0d",
                             bus.dout_valid, mon_e.vld, bus.dout, mon_e.dout, bus.err_mask, mon_e.mask,
                             bus.err_flag, bus.busy, mon_e.busy, bus.inj_count, mon_e.cnt,
                             bus4.inj_count, mon_e.cnt4);
                end
            end else if (rst && bus.dout_valid) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: dout_valid 1 with nothing expected");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b0;
        bus.en        = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.mode      = 2'b00;
        bus.rate      = '0;
        bus.num_flips = 3'd4;
        bus.trigger   = 1'b0;
        bus.burst_len = '0;
        bus.clr_count = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dout_valid", 80'(bus.dout_valid), 80'd0);
        chk("rst_dout", bus.dout, 80'd0);
        chk("rst_inj_count", 80'(bus.inj_count), 80'd0);
        chk("rst_busy", 80'(bus.busy), 80'd0);
        rst = 1'b1;

        // Pass-through with mode off.
        for (int i = 0; i < 10; i++) step(1'b1, 80'h1234_5678_9ABC_DEF0_1357 ^ 80'(i), 1'b0, 1'b0);
        idle(1);
        chk("pass_inj_count", 80'(bus.inj_count), 80'd0);

        // Random mode, rate 0: never corrupts.
        t_mode = 2'b01;
        t_rate = 16'h0000;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) step(1'b1, rnd80(), 1'b0, 1'b0);
        idle(1);
        chk("rand0_inj_count", 80'(bus.inj_count), 80'd0);

        // Random mode, full rate; the 4-bit counter saturates.
        t_rate = 16'hFFFF;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) step(1'b1, rnd80(), 1'b0, 1'b0);
        idle(1);
        chk("randfull_ge999", 80'(bus.inj_count >= 32'd999), 80'd1);
        chk("cnt4_saturated", 80'(bus4.inj_count), 80'hF);

        // Random mode, rate 1/64 with three flips per word.
        t_rate = 16'h0400;
        t_nf   = 3'd3;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) step(1'b1, rnd80(), 1'b0, 1'b0);
        idle(1);
        chk("rand64_in_range", 80'(bus.inj_count >= 32'd4 && bus.inj_count <= 32'd40), 80'd1);

        // Clear beats a simultaneous injection.
        t_rate = 16'hFFFF;
        step(1'b1, rnd80(), 1'b0, 1'b1);
        idle(1);
        chk("clr_priority", 80'(bus.inj_count), 80'd0);

        // Disabled: pass-through, state held, trigger ignored.
        t_en = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, rnd80(), 1'b1, 1'b0);
        t_en = 1'b1;

        // Single-shot: trigger word is clean, second trigger while armed ignored.
        t_mode = 2'b10;
        t_nf   = 3'd1;
        step(1'b1, rnd80(), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, rnd80(), 1'b0, 1'b0);
        idle(1);
        chk("shot_inj_count", 80'(bus.inj_count), 80'd1);
        chk("shot_busy", 80'(bus.busy), 80'd0);

        // Mode change while armed aborts without corrupting.
        step(1'b0, '0, 1'b1, 1'b0);
        t_mode = 2'b00;
        step(1'b1, rnd80(), 1'b0, 1'b0);

        // Burst of 3 with valid on alternate cycles.
        t_mode = 2'b11;
        t_blen = 8'd3;
        t_nf   = 3'd2;
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step((i % 2) == 0, rnd80(), 1'b0, 1'b0);
        idle(1);
        chk("burst3_inj_count", 80'(bus.inj_count), 80'd3);
        chk("burst3_busy", 80'(bus.busy), 80'd0);

        // Burst length 0 behaves as 1.
        t_blen = 8'd0;
        step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, rnd80(), 1'b0, 1'b0);
        idle(1);
        chk("burst0_inj_count", 80'(bus.inj_count), 80'd1);

        // Wrap: pos0 = 78 with four flips hits bits 78, 79, 0, 1.
        t_nf = 3'd4;
        seek_pos(78);
        t_mode = 2'b10;
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 80'd0, 1'b0, 1'b0);
        idle(1);
        chk("wrap_mask", bus.err_mask, 80'hC000_0000_0000_0000_0003);

        // Clamp: seven requested flips become four at pos0 = 10.
        t_nf = 3'd7;
        seek_pos(10);
        t_mode = 2'b10;
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 80'd0, 1'b0, 1'b0);
        idle(1);
        chk("clamp_mask", bus.err_mask, 80'h0000_0000_0000_0000_3C00);

        // Reset in the middle of a burst.
        t_mode = 2'b11;
        t_blen = 8'd10;
        t_nf   = 3'd1;
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rnd80(), 1'b0, 1'b0);
        step(1'b1, rnd80(), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.din_valid = 1'b0;
        bus.trigger   = 1'b0;
        #1;
        chk("abort_dout_valid", 80'(bus.dout_valid), 80'd0);
        chk("abort_dout", bus.dout, 80'd0);
        chk("abort_mask", bus.err_mask, 80'd0);
        chk("abort_flag", 80'(bus.err_flag), 80'd0);
        chk("abort_inj_count", 80'(bus.inj_count), 80'd0);
        chk("abort_busy", 80'(bus.busy), 80'd0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, rnd80(), 1'b0, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
